loop_buffer: RTL and testbench
==============================

LOOP_BUFFER -- requirements
Module: loop_buffer

Interface
REQ-001 Parameter XLEN, default 32: instruction, immediate and PC width.
REQ-002 Parameter DEPTH, default 16: buffer entries, power of two, 4..64.
REQ-003 Parameter PTR_W, default $clog2(DEPTH): pointer and length width.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: curr_PC, instruction and immediate are valid this cycle.
REQ-007 Port curr_PC, input, XLEN: PC of the fetched instruction.
REQ-008 Port instruction, input, XLEN: fetched instruction word.
REQ-009 Port immediate, input, XLEN: decoded signed branch offset, counted in instructions (not bytes).
REQ-010 Port mispredict, input, 1: replayed loop branch resolved not-taken.
REQ-011 Port block_signal, output, 1: stall upstream fetch; the buffer is supplying instructions.
REQ-012 Port flush, output, 1: one-cycle pulse to flush the pipeline after a mispredict.
REQ-013 Port new_pc, output, XLEN: PC associated with out_instruction; on flush, the redirect target.
REQ-014 Port out_valid, output, 1: out_instruction is valid.
REQ-015 Port out_instruction, output, XLEN: instruction sent downstream.

Function
REQ-016 States SHALL be IDLE, CAPTURE and REPLAY, encoded in 2 bits.
REQ-017 Loop-branch detect: in_valid=1, instruction[6:0]=7'b1100011 and immediate[XLEN-1]=1.
REQ-018 Loop length L = 1 - immediate (the branch is included in L).
REQ-019 Loop start_pc = curr_PC + (immediate << 2), computed modulo 2^XLEN.
REQ-020 IDLE, on detect with 2 <= L <= DEPTH: latch start_pc, L and branch_pc=curr_PC, clear wr_ptr, go to CAPTURE.
REQ-021 IDLE, on detect with L outside 2..DEPTH: stay in IDLE; no state is latched.
REQ-022 CAPTURE, each in_valid cycle with curr_PC = start_pc + 4*wr_ptr: write buf[wr_ptr] and increment wr_ptr.
REQ-023 CAPTURE, when wr_ptr=L-1 is written and curr_PC=branch_pc: go to REPLAY and clear rd_ptr.
REQ-024 CAPTURE, on any PC mismatch with in_valid=1: abort to IDLE with no output effect; the mismatching cycle is not re-examined for detect.
REQ-025 CAPTURE, cycles with in_valid=0: hold state and pointers.
REQ-026 IDLE and CAPTURE outputs: pure combinational pass-through, with out_instruction=instruction, new_pc=curr_PC, out_valid=in_valid and block_signal=0.
REQ-027 REPLAY outputs, every cycle: block_signal=1, out_valid=1, out_instruction=buf[rd_ptr] and new_pc=start_pc+4*rd_ptr.
REQ-028 REPLAY pointer: rd_ptr advances every cycle and wraps from L-1 to 0.
REQ-029 REPLAY input: in_valid and fetch inputs are ignored.
REQ-030 Replay latency: the first replayed word (rd_ptr=0) appears in the cycle after the capturing branch is sampled.
REQ-031 REPLAY, mispredict=1 sampled: next cycle flush=1, new_pc=branch_pc+4, out_valid=0, block_signal=0, and state returns to IDLE.
REQ-032 flush SHALL be exactly one cycle wide and asserted only on a REPLAY exit.
REQ-033 mispredict in IDLE or CAPTURE is ignored.
REQ-034 mispredict has priority over pointer advance.

Reset
REQ-035 reset=0 asynchronously forces state=IDLE, wr_ptr=rd_ptr=0, L=0, start_pc=branch_pc=0, flush=0 and all statistics to 0.
REQ-036 During reset: block_signal=0 and out_valid=in_valid (pass-through).
REQ-037 Buffer contents are not reset.
REQ-038 Reset asserted mid-CAPTURE or mid-REPLAY abandons the loop; no flush is issued.

Configuration
REQ-039 With macro LOOP_BUFFER_STATS_EN defined: add output replay_count, 16 bits.
REQ-040 replay_count increments on each rd_ptr wrap from L-1 to 0.
REQ-041 replay_count saturates at 16'hFFFF and clears on reset.
REQ-042 With LOOP_BUFFER_STATS_EN undefined: the port and its counter logic are absent; all other behaviour is identical.

Verification
REQ-043 Capture and replay: feed PCs 0x100,0x104,0x108,0x10C, with 0xFC000AE3 at 0x10C and imm=-3, twice -> CAPTURE on the first branch; the cycle after the second branch block_signal=1 and new_pc cycles 0x100,0x104,0x108,0x10C,0x100 with matching words.
REQ-044 Mispredict exit: mispredict=1 during REPLAY -> next cycle flush=1, new_pc=0x110, block_signal=0; the following cycle flush=0 and state is IDLE.
REQ-045 Oversize loop: imm=-DEPTH (L=DEPTH+1) -> state stays IDLE; outputs stay pass-through.
REQ-046 Capture abort: second pass with PC 0x11C in place of 0x10C -> return to IDLE, block_signal never set.
REQ-047 Async reset: reset=0 between clock edges during REPLAY -> block_signal=0 immediately, flush=0, IDLE.
REQ-048 Statistics: with LOOP_BUFFER_STATS_EN, 3 full iterations of a 4-word loop -> replay_count=3.

Source files
------------

// File: rtl/loop_buffer.sv
// Loop buffer: captures a short backward-branch loop from fetch, then replays it
// while stalling upstream fetch. Define LOOP_BUFFER_STATS_EN to add replay_count.
module loop_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [XLEN-1:0] curr_PC,
   input  logic [XLEN-1:0] instruction,
   input  logic [XLEN-1:0] immediate,
   input  logic            mispredict,
   output logic            block_signal,
   output logic            flush,
   output logic [XLEN-1:0] new_pc,
   output logic            out_valid,
   output logic [XLEN-1:0] out_instruction
`ifdef LOOP_BUFFER_STATS_EN
   ,
   output logic [15:0]     replay_count
`endif
);

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_REPLAY  = 2'd2
   } state_t;

   state_t           state_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_next;
   // Loop length is held as L-1 so that L=DEPTH still fits in a pointer.
   logic [PTR_W-1:0] last_idx_reg;
   logic [XLEN-1:0]  start_pc_reg;
   logic [XLEN-1:0]  branch_pc_reg;
   logic             flush_reg;

   logic [XLEN-1:0]  buf_mem [DEPTH];
   logic [XLEN-1:0]  rd_data_reg;

   logic [XLEN-1:0]  loop_len;
   logic [XLEN-1:0]  loop_start;
   logic [XLEN-1:0]  capture_pc;
   logic [XLEN-1:0]  replay_pc;
   logic             loop_branch;
   logic             len_ok;
   logic             pc_match;
   logic             capture_last;
   logic             rd_wrap;

   assign loop_branch  = in_valid && (instruction[6:0] == OPC_BRANCH) && immediate[XLEN-1];
   assign loop_len     = XLEN'(1) - immediate;
   assign len_ok       = (loop_len >= XLEN'(2)) && (loop_len <= XLEN'(DEPTH));
   assign loop_start   = curr_PC + (immediate << 2);
   assign capture_pc   = start_pc_reg + XLEN'({wr_ptr_reg, 2'b00});
   assign replay_pc    = start_pc_reg + XLEN'({rd_ptr_reg, 2'b00});
   assign pc_match     = in_valid && (curr_PC == capture_pc);
   assign capture_last = pc_match && (wr_ptr_reg == last_idx_reg) && (curr_PC == branch_pc_reg);
   assign rd_wrap      = (rd_ptr_reg == last_idx_reg);

   // Next read index also addresses the buffer a cycle early, so the registered
   // read data always lines up with rd_ptr_reg during replay.
   always_comb begin
      rd_ptr_next = '0;
      if (state_reg == ST_REPLAY) begin
         if (mispredict) begin
            rd_ptr_next = rd_ptr_reg;
         end else if (rd_wrap) begin
            rd_ptr_next = '0;
         end else begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((state_reg == ST_CAPTURE) && pc_match) begin
         buf_mem[wr_ptr_reg] <= instruction;
      end
      rd_data_reg <= buf_mem[rd_ptr_next];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         last_idx_reg  <= '0;
         start_pc_reg  <= '0;
         branch_pc_reg <= '0;
         flush_reg     <= 1'b0;
      end else begin
         flush_reg  <= 1'b0;
         rd_ptr_reg <= rd_ptr_next;
         case (state_reg)
            ST_IDLE: begin
               if (loop_branch && len_ok) begin
                  start_pc_reg  <= loop_start;
                  branch_pc_reg <= curr_PC;
                  last_idx_reg  <= loop_len[PTR_W-1:0] - PTR_W'(1);
                  wr_ptr_reg    <= '0;
                  state_reg     <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (in_valid) begin
                  if (capture_last) begin
                     state_reg <= ST_REPLAY;
                  end else if (pc_match) begin
                     wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                  end else begin
                     // Fetch left the loop body; the offending word is dropped.
                     state_reg <= ST_IDLE;
                  end
               end
            end
            ST_REPLAY: begin
               if (mispredict) begin
                  flush_reg <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      out_instruction = instruction;
      new_pc          = curr_PC;
      out_valid       = in_valid;
      block_signal    = 1'b0;
      if (flush_reg) begin
         new_pc    = branch_pc_reg + XLEN'(4);
         out_valid = 1'b0;
      end else if (state_reg == ST_REPLAY) begin
         block_signal    = 1'b1;
         out_valid       = 1'b1;
         out_instruction = rd_data_reg;
         new_pc          = replay_pc;
      end
   end

   assign flush = flush_reg;

`ifdef LOOP_BUFFER_STATS_EN
   logic [15:0] replay_count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         replay_count_reg <= '0;
      end else if ((state_reg == ST_REPLAY) && !mispredict && rd_wrap &&
                   (replay_count_reg != 16'hFFFF)) begin
         replay_count_reg <= replay_count_reg + 16'd1;
      end
   end

   assign replay_count = replay_count_reg;
`endif

endmodule

// File: tb/tb_loop_buffer.sv
// Directed bench for loop_buffer: capture/replay, mispredict exit, length
// bounds, capture abort, asynchronous reset and (optionally) replay statistics.
module tb_loop_buffer;

   localparam int          XLEN    = 32;
   localparam int          DEPTH   = 16;
   localparam logic [31:0] BR_WORD = 32'hFC000AE3;
   localparam logic [31:0] JUNK_PC = 32'hDEADBEE0;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] curr_PC;
   logic [31:0] instruction;
   logic [31:0] immediate;
   logic        mispredict;
   logic        block_signal;
   logic        flush;
   logic [31:0] new_pc;
   logic        out_valid;
   logic [31:0] out_instruction;
`ifdef LOOP_BUFFER_STATS_EN
   logic [15:0] replay_count;
`endif

   int checks   = 0;
   int failures = 0;

   loop_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .curr_PC        (curr_PC),
      .instruction    (instruction),
      .immediate      (immediate),
      .mispredict     (mispredict),
      .block_signal   (block_signal),
      .flush          (flush),
      .new_pc         (new_pc),
      .out_valid      (out_valid),
      .out_instruction(out_instruction)
`ifdef LOOP_BUFFER_STATS_EN
      ,
      .replay_count   (replay_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] nop_at(input logic [31:0] pc);
      return {pc[19:0], 12'h093};
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] base, input int n, input int idx);
      logic [31:0] pc;
      pc = base + 32'(4 * idx);
      return (idx == n - 1) ? BR_WORD : nop_at(pc);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One fetched word while the buffer is not replaying: outputs must pass through.
   task automatic feed(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] imm, input logic mis);
      @(negedge clk);
      in_valid    = 1'b1;
      curr_PC     = pc;
      instruction = instr;
      immediate   = imm;
      mispredict  = mis;
      #1;
      $display("fetch  pc=%h instr=%h imm=%0d mis=%0b", pc, instr, $signed(imm), mis);
      check_val("pass_pc", new_pc, pc);
      check_val("pass_instr", out_instruction, instr);
      check_val("pass_block", 32'(block_signal), 32'd0);
      check_val("pass_flush", 32'(flush), 32'd0);
   endtask

   task automatic run_loop(input logic [31:0] base, input int n, input int imm_br, input int mis_idx);
      for (int k = 0; k < n; k++) begin
         feed(base + 32'(4 * k), word_at(base, n, k),
              (k == n - 1) ? 32'(imm_br) : 32'd0, k == mis_idx);
      end
   endtask

   // Replay cycles; fetch inputs carry junk that the buffer must ignore.
   task automatic expect_replay(input logic [31:0] base, input int n, input int count);
      for (int j = 0; j < count; j++) begin
         int idx = j % n;
         @(negedge clk);
         in_valid    = 1'b1;
         curr_PC     = JUNK_PC;
         instruction = BR_WORD;
         immediate   = 32'hFFFF_FFFD;
         mispredict  = 1'b0;
         #1;
         $display("replay pc=%h instr=%h", new_pc, out_instruction);
         check_val("rep_block", 32'(block_signal), 32'd1);
         check_val("rep_valid", 32'(out_valid), 32'd1);
         check_val("rep_pc", new_pc, base + 32'(4 * idx));
         check_val("rep_instr", out_instruction, word_at(base, n, idx));
      end
   endtask

   task automatic mispredict_exit(input logic [31:0] flush_pc);
      @(negedge clk);
      in_valid   = 1'b0;
      mispredict = 1'b1;
      #1;
      check_val("mis_hold_block", 32'(block_signal), 32'd1);
      @(negedge clk);
      mispredict  = 1'b0;
      in_valid    = 1'b1;
      curr_PC     = 32'h9000_0000;
      instruction = nop_at(32'h9000_0000);
      immediate   = 32'd0;
      #1;
      $display("flush  pc=%h flush=%0b", new_pc, flush);
      check_val("fl_flush", 32'(flush), 32'd1);
      check_val("fl_pc", new_pc, flush_pc);
      check_val("fl_valid", 32'(out_valid), 32'd0);
      check_val("fl_block", 32'(block_signal), 32'd0);
      @(negedge clk);
      curr_PC     = 32'h9000_0004;
      instruction = nop_at(32'h9000_0004);
      #1;
      check_val("post_fl_flush", 32'(flush), 32'd0);
      check_val("post_fl_block", 32'(block_signal), 32'd0);
      check_val("post_fl_pc", new_pc, 32'h9000_0004);
      check_val("post_fl_valid", 32'(out_valid), 32'd1);
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      in_valid   = 1'b0;
      mispredict = 1'b0;
      #1;
      $display("idle   %s block=%0b valid=%0b", tag, block_signal, out_valid);
      check_val({tag, "_block"}, 32'(block_signal), 32'd0);
      check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
      check_val({tag, "_flush"}, 32'(flush), 32'd0);
   endtask

   initial begin
      reset       = 1'b0;
      in_valid    = 1'b0;
      curr_PC     = '0;
      instruction = '0;
      immediate   = '0;
      mispredict  = 1'b0;
      repeat (2) @(negedge clk);
      in_valid    = 1'b1;
      curr_PC     = 32'h0000_0055;
      instruction = 32'h1234_5013;
      #1;
      check_val("rst_block", 32'(block_signal), 32'd0);
      check_val("rst_flush", 32'(flush), 32'd0);
      check_val("rst_valid", 32'(out_valid), 32'd1);
      check_val("rst_pc", new_pc, 32'h0000_0055);
      check_val("rst_instr", out_instruction, 32'h1234_5013);
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;

      // 4-word loop; mispredicts in IDLE and CAPTURE are ignored
      run_loop(32'h100, 4, -3, 0);
      run_loop(32'h100, 4, -3, 1);
      expect_replay(32'h100, 4, 5);
      mispredict_exit(32'h110);

      // Largest accepted loop (L=DEPTH)
      run_loop(32'h300, 16, -15, -1);
      run_loop(32'h300, 16, -15, -1);
      expect_replay(32'h300, 16, 17);
      mispredict_exit(32'h340);

      // Smallest accepted loop (L=2)
      run_loop(32'h400, 2, -1, -1);
      run_loop(32'h400, 2, -1, -1);
      expect_replay(32'h400, 2, 3);
      mispredict_exit(32'h408);

      // Oversize loop (L=DEPTH+1) is never captured
      run_loop(32'h1C0, 17, -16, -1);
      run_loop(32'h1C0, 17, -16, -1);
      idle_check("over0");
      idle_check("over1");

      // Capture abort: the mismatching branch at 0x11C must not start a capture
      run_loop(32'h100, 4, -3, -1);
      feed(32'h100, nop_at(32'h100), 32'd0, 1'b0);
      feed(32'h104, nop_at(32'h104), 32'd0, 1'b0);
      feed(32'h108, nop_at(32'h108), 32'd0, 1'b0);
      feed(32'h11C, BR_WORD, 32'hFFFF_FFFD, 1'b0);
      run_loop(32'h110, 4, -3, -1);
      idle_check("abort0");
      idle_check("abort1");

      // Complete the capture of the 0x110 loop, then reset asynchronously mid-replay
      run_loop(32'h110, 4, -3, -1);
      expect_replay(32'h110, 4, 1);
      #2;
      reset = 1'b0;
      #1;
      $display("areset block=%0b flush=%0b pc=%h", block_signal, flush, new_pc);
      check_val("arst_block", 32'(block_signal), 32'd0);
      check_val("arst_flush", 32'(flush), 32'd0);
      check_val("arst_valid", 32'(out_valid), 32'd1);
      check_val("arst_pc", new_pc, JUNK_PC);
      @(negedge clk);
      reset = 1'b1;
      idle_check("arst_post0");
      idle_check("arst_post1");

`ifdef LOOP_BUFFER_STATS_EN
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("stat_rst", 32'(replay_count), 32'd0);
      reset = 1'b1;
      run_loop(32'h100, 4, -3, -1);
      run_loop(32'h100, 4, -3, -1);
      expect_replay(32'h100, 4, 13);
      check_val("stat_three", 32'(replay_count), 32'd3);
      mispredict_exit(32'h110);
      check_val("stat_hold", 32'(replay_count), 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
